rv32_mem_arbiter: RTL and testbench
===================================

// Module: rv32_mem_arbiter
// PURPOSE
//  Shares one single-port memory between the core's instruction-fetch and data (mem-stage) ports.
//  Grants one requester per transaction, forwards its request downstream and routes done/rdata back.
//  Discards responses for requests withdrawn mid-flight (fetch flush on jump).
//  Raises a sticky error when memory fails to answer in time.
// PARAMETERS
//  DATA_FIRST  1    when both request in IDLE in the same cycle: 1 = grant data, 0 = grant instr
//  TIMEOUT     255  max cycles a granted transaction waits for mem_done; 0 disables watchdog
//  ADDR_W      32   address width
// PORTS
//  clk           in   1       clock, rising edge
//  resetn        in   1       asynchronous active-low reset
//  i_req_valid   in   1       instr request, held high until i_done
//  i_req_addr    in   ADDR_W  instr address
//  i_done        out  1       1-cycle pulse: instr transaction complete, i_rdata valid
//  i_rdata       out  32      instr read data
//  d_req_valid   in   1       data request, held high until d_done
//  d_req_we      in   1       1 = store
//  d_req_addr    in   ADDR_W  data address
//  d_req_wdata   in   32      store data
//  d_req_wstrb   in   4       byte enables
//  d_done        out  1       1-cycle pulse: data transaction complete, d_rdata valid
//  d_rdata       out  32      data read data
//  m_req_valid   out  1       downstream request valid
//  m_req_we      out  1       downstream write enable (0 for instr grant)
//  m_req_addr    out  ADDR_W  downstream address
//  m_req_wdata   out  32      downstream store data (0 for instr grant)
//  m_req_wstrb   out  4       downstream byte enables (0 for instr grant)
//  m_done        in   1       memory completion pulse; m_rdata valid same cycle
//  m_rdata       in   32      memory read data
//  err_timeout   out  1       sticky: watchdog expired
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, all outputs 0, wd counter 0, err_timeout=0.
//  States: IDLE, GNT_I, GNT_D. m_req_* driven combinationally from state + latched request.
//  IDLE: d&i valid -> GNT_D if DATA_FIRST else GNT_I; single valid -> its GNT; none -> stay.
//  Grant is registered: request seen in IDLE at cycle N -> m_req_valid=1 from N+1.
//  On grant entry, addr/we/wdata/wstrb latched; m_req_* constant until m_done.
//  GNT_x: m_req_valid=1. On m_done: x_done=1 and x_rdata=m_rdata same cycle (comb).
//    Only if x_req_valid still 1; otherwise response discarded, no pulse (aborted).
//  Next state on m_done: other requester valid -> its GNT directly (no idle bubble);
//    else IDLE. The just-served requester is never re-granted on its done cycle.
//  Requester dropping valid mid-grant: grant held, memory transaction completes, response dropped.
//  Watchdog: counter clears on grant entry, +1 per GNT cycle without m_done.
//    Reaching TIMEOUT: err_timeout<=1 (sticky until reset), state->IDLE, no done pulse.
//    Counter saturates; never wraps. Inactive when TIMEOUT=0.
//  i_done and d_done never high in the same cycle; m_done in IDLE is ignored.
//  x_rdata = 0 when x_done = 0.
// TESTING
//  Instr only, addr 0x100, mem answers 2 cycles after grant -> m_req_valid at N+1, i_done at N+3.
//  Both valid at N, DATA_FIRST=1 -> GNT_D first; d_done then GNT_I next cycle, no IDLE bubble.
//  Store 0xDEADBEEF, wstrb 0xF, addr 0x2000 -> m_req_we=1, fields stable until m_done, d_done pulse.
//  i_req_valid dropped 1 cycle after grant -> m_req_valid held; m_done gives no i_done; return IDLE.
//  TIMEOUT=4, memory never answers -> err_timeout=1 after 4 grant cycles, state IDLE, stays set.
//  resetn low mid-GNT_D -> outputs 0 immediately; after release, fresh arbitration from IDLE.

Source files
------------

// File: rtl/rv32_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data ports.
// Grant registered one cycle after request; done/rdata routed combinationally; a watchdog flags a stuck memory.
module rv32_mem_arbiter #(
    parameter bit DATA_FIRST = 1'b1,
    parameter int TIMEOUT    = 255,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_done,
    output logic [31:0]       i_rdata,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    input  logic [3:0]        d_req_wstrb,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              m_req_valid,
    output logic              m_req_we,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [31:0]       m_req_wdata,
    output logic [3:0]        m_req_wstrb,
    input  logic              m_done,
    input  logic [31:0]       m_rdata,
    output logic              err_timeout
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_we;
    logic [31:0]         lat_wdata;
    logic [3:0]          lat_wstrb;
    logic [WD_W-1:0]     wd_cnt;
    logic                wd_fire;

    // Completion in the same cycle as the last allowed wait beats the watchdog.
    always_comb begin
        wd_fire = 1'b0;
        if (TIMEOUT != 0 && state != IDLE && !m_done && wd_cnt == WD_W'(TIMEOUT - 1))
            wd_fire = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_req_valid && (DATA_FIRST || !i_req_valid))
                    state_nxt = GNT_D;
                else if (i_req_valid)
                    state_nxt = GNT_I;
            end
            GNT_I: begin
                if (m_done)
                    state_nxt = d_req_valid ? GNT_D : IDLE;
                else if (wd_fire)
                    state_nxt = IDLE;
            end
            GNT_D: begin
                if (m_done)
                    state_nxt = i_req_valid ? GNT_I : IDLE;
                else if (wd_fire)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_req_valid = (state != IDLE);
        m_req_addr  = (state != IDLE) ? lat_addr : '0;
        m_req_we    = (state == GNT_D) ? lat_we : 1'b0;
        m_req_wdata = (state == GNT_D) ? lat_wdata : 32'h0;
        m_req_wstrb = (state == GNT_D) ? lat_wstrb : 4'h0;
        // A withdrawn requester gets no pulse; its response is dropped here.
        i_done      = (state == GNT_I) && m_done && i_req_valid;
        d_done      = (state == GNT_D) && m_done && d_req_valid;
        i_rdata     = i_done ? m_rdata : 32'h0;
        d_rdata     = d_done ? m_rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_we      <= 1'b0;
            lat_wdata   <= 32'h0;
            lat_wstrb   <= 4'h0;
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == GNT_D && state != GNT_D) begin
                lat_addr  <= d_req_addr;
                lat_we    <= d_req_we;
                lat_wdata <= d_req_wdata;
                lat_wstrb <= d_req_wstrb;
                wd_cnt    <= '0;
            end else if (state_nxt == GNT_I && state != GNT_I) begin
                lat_addr  <= i_req_addr;
                lat_we    <= 1'b0;
                lat_wdata <= 32'h0;
                lat_wstrb <= 4'h0;
                wd_cnt    <= '0;
            end else if (state != IDLE && !m_done && wd_cnt != WD_W'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_fire)
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter (DATA_FIRST=1, TIMEOUT=4).
module tb_rv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        m_req_valid;
    logic        m_req_we;
    logic [31:0] m_req_addr;
    logic [31:0] m_req_wdata;
    logic [3:0]  m_req_wstrb;
    logic        m_done;
    logic [31:0] m_rdata;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;

    rv32_mem_arbiter #(.DATA_FIRST(1'b1), .TIMEOUT(4), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
        .i_done(i_done), .i_rdata(i_rdata),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_done(d_done), .d_rdata(d_rdata),
        .m_req_valid(m_req_valid), .m_req_we(m_req_we), .m_req_addr(m_req_addr),
        .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_done(m_done), .m_rdata(m_rdata),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, then let comb outputs settle after drives.
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic clear_inputs;
        i_req_valid = 1'b0; i_req_addr  = 32'h0;
        d_req_valid = 1'b0; d_req_we    = 1'b0; d_req_addr = 32'h0;
        d_req_wdata = 32'h0; d_req_wstrb = 4'h0;
        m_done      = 1'b0; m_rdata     = 32'h0;
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        #12;
        chk("rst_m_req_valid", {31'h0, m_req_valid}, 32'h0);
        chk("rst_m_req_addr",  m_req_addr, 32'h0);
        chk("rst_err",         {31'h0, err_timeout}, 32'h0);
        chk("rst_done",        {30'h0, i_done, d_done}, 32'h0);
        cyc();
        resetn = 1'b1;

        // m_done while idle must be ignored
        cyc();
        m_done = 1'b1; m_rdata = 32'hFFFF_0000;
        settle();
        chk("idle_mdone_done",  {30'h0, i_done, d_done}, 32'h0);
        chk("idle_mdone_rdata", i_rdata | d_rdata, 32'h0);

        // Instruction fetch, memory answers two cycles after grant
        cyc();
        clear_inputs();
        i_req_valid = 1'b1; i_req_addr = 32'h100;
        settle();
        chk("if_cycN_valid", {31'h0, m_req_valid}, 32'h0);
        cyc(); settle();
        chk("if_grant_valid", {31'h0, m_req_valid}, 32'h1);
        chk("if_grant_addr",  m_req_addr, 32'h100);
        chk("if_grant_we",    {31'h0, m_req_we}, 32'h0);
        chk("if_grant_wstrb", {28'h0, m_req_wstrb}, 32'h0);
        cyc(); settle();
        chk("if_wait_done", {31'h0, i_done}, 32'h0);
        cyc();
        m_done = 1'b1; m_rdata = 32'h0000_0013;
        settle();
        chk("if_done",  {31'h0, i_done}, 32'h1);
        chk("if_rdata", i_rdata, 32'h13);
        chk("if_no_ddone", {31'h0, d_done}, 32'h0);
        cyc();
        clear_inputs();
        settle();
        chk("if_idle_valid", {31'h0, m_req_valid}, 32'h0);
        chk("if_idle_rdata", i_rdata, 32'h0);

        // Simultaneous requests: data first, then instr with no idle bubble
        cyc();
        i_req_valid = 1'b1; i_req_addr = 32'h104;
        d_req_valid = 1'b1; d_req_addr = 32'h40;
        cyc();
        m_done = 1'b1; m_rdata = 32'hAAAA_5555;
        settle();
        chk("both_first_addr", m_req_addr, 32'h40);
        chk("both_ddone",      {30'h0, i_done, d_done}, 32'h1);
        chk("both_drdata",     d_rdata, 32'hAAAA_5555);
        cyc();
        d_req_valid = 1'b0; m_done = 1'b0;
        settle();
        chk("both_second_valid", {31'h0, m_req_valid}, 32'h1);
        chk("both_second_addr",  m_req_addr, 32'h104);
        chk("both_second_noddone", {31'h0, d_done}, 32'h0);
        m_done = 1'b1; m_rdata = 32'h0000_1234;
        settle();
        chk("both_idone",  {30'h0, i_done, d_done}, 32'h2);
        chk("both_irdata", i_rdata, 32'h1234);
        cyc();
        clear_inputs();
        settle();
        chk("both_idle", {31'h0, m_req_valid}, 32'h0);

        // Store with fields latched on grant
        cyc();
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h2000;
        d_req_wdata = 32'hDEAD_BEEF; d_req_wstrb = 4'hF;
        cyc();
        d_req_wdata = 32'h0; d_req_addr = 32'h0; d_req_wstrb = 4'h0;
        settle();
        chk("st_we",    {31'h0, m_req_we}, 32'h1);
        chk("st_addr",  m_req_addr, 32'h2000);
        chk("st_wdata", m_req_wdata, 32'hDEAD_BEEF);
        chk("st_wstrb", {28'h0, m_req_wstrb}, 32'hF);
        cyc();
        m_done = 1'b1;
        settle();
        chk("st_hold_wdata", m_req_wdata, 32'hDEAD_BEEF);
        chk("st_ddone", {31'h0, d_done}, 32'h1);
        cyc();
        clear_inputs();
        settle();
        chk("st_idle", {31'h0, m_req_valid}, 32'h0);

        // Fetch withdrawn mid-flight
        cyc();
        i_req_valid = 1'b1; i_req_addr = 32'h300;
        cyc();
        i_req_valid = 1'b0;
        cyc(); settle();
        chk("ab_held_valid", {31'h0, m_req_valid}, 32'h1);
        chk("ab_held_addr",  m_req_addr, 32'h300);
        m_done = 1'b1; m_rdata = 32'h7777_7777;
        settle();
        chk("ab_no_idone", {31'h0, i_done}, 32'h0);
        chk("ab_rdata",    i_rdata, 32'h0);
        cyc();
        m_done = 1'b0;
        settle();
        chk("ab_idle", {31'h0, m_req_valid}, 32'h0);

        // Watchdog: memory never answers
        cyc();
        i_req_valid = 1'b1; i_req_addr = 32'h400;
        cyc(); cyc(); cyc(); cyc(); settle();
        chk("wd_4th_valid", {31'h0, m_req_valid}, 32'h1);
        chk("wd_4th_err",   {31'h0, err_timeout}, 32'h0);
        cyc();
        i_req_valid = 1'b0;
        settle();
        chk("wd_fired_err",   {31'h0, err_timeout}, 32'h1);
        chk("wd_fired_valid", {31'h0, m_req_valid}, 32'h0);
        chk("wd_fired_done",  {31'h0, i_done}, 32'h0);
        cyc(); cyc(); settle();
        chk("wd_sticky", {31'h0, err_timeout}, 32'h1);

        // Asynchronous reset in the middle of a data grant
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h80;
        d_req_wdata = 32'h1111_2222; d_req_wstrb = 4'h3;
        cyc(); settle();
        chk("ar_pre_valid", {31'h0, m_req_valid}, 32'h1);
        resetn = 1'b0;
        #1;
        chk("ar_valid", {31'h0, m_req_valid}, 32'h0);
        chk("ar_we",    {31'h0, m_req_we}, 32'h0);
        chk("ar_wdata", m_req_wdata, 32'h0);
        chk("ar_err",   {31'h0, err_timeout}, 32'h0);
        clear_inputs();
        cyc();
        resetn = 1'b1;
        cyc();
        i_req_valid = 1'b1; i_req_addr = 32'h500;
        d_req_valid = 1'b1; d_req_addr = 32'h600;
        cyc(); settle();
        chk("ar_fresh_addr", m_req_addr, 32'h600);
        chk("ar_fresh_err",  {31'h0, err_timeout}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
